// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and line/word geometry for the data cache
package dcache_pkg;
    typedef enum logic [2:0] {LOOKUP, WRITEBACK, FILL, FLUSH_SCAN, FLUSH_WB} state_t;
    localparam int line_w     = 256;
    localparam int word_w     = 32;
    localparam int byte_lanes = 4;
    localparam int line_bytes = line_w / 8;
    localparam int word_lo    = 2;
    localparam int word_sel_w = 3;
endpackage

// File: rtl/plru_tree.sv
// plru_tree: tree pseudo-LRU victim selection and update for one set
module plru_tree #(
    parameter int num_ways = 4,
    parameter int w_bits   = $clog2(num_ways)
) (
    input  logic [num_ways-2:0] bits,
    input  logic [w_bits-1:0]   way,
    output logic [w_bits-1:0]   victim,
    output logic [num_ways-2:0] next_bits
);
    int n, m;
    // walk from the root along the node bits down to the least-recently-used leaf
    always_comb begin
        n = 0;
        for (int l = 0; l < w_bits; l++) n = 2 * n + 1 + int'(bits[n]);
        victim = w_bits'(n - (num_ways - 1));
    end
    // along the accessed way's path, point every node at the opposite subtree
    always_comb begin
        next_bits = bits;
        m = 0;
        for (int l = 0; l < w_bits; l++) begin
            next_bits[m] = ~way[w_bits-1-l];
            m = 2 * m + 1 + int'(way[w_bits-1-l]);
        end
    end
endmodule

// File: rtl/nway_datacache.sv
// nway_datacache: N-way write-back, write-allocate L1 data cache with PLRU and flush
module nway_datacache #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 4,
    parameter int s_tag    = 32 - s_offset - s_index
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    input  logic         flush,
    output logic         flush_done,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    import dcache_pkg::*;
    localparam int num_sets = 2 ** s_index;
    localparam int w_bits   = $clog2(num_ways);
    localparam int c_bits   = s_index + w_bits;

    state_t state, next_state;
    logic                valid [num_sets][num_ways];
    logic                dirty [num_sets][num_ways];
    logic [s_tag-1:0]    tag_arr [num_sets][num_ways];
    logic [line_w-1:0]   data_arr [num_sets][num_ways];
    logic [num_ways-2:0] plru [num_sets];
    logic [c_bits-1:0]   cnt;
    logic [w_bits-1:0]   victim_q, hit_way, inv_way, plru_victim, victim_sel;
    logic [num_ways-2:0] plru_next;
    logic [line_w-1:0]   hit_line, merged;
    logic [line_bytes-1:0] byte_mask;
    logic                hit, any_inv, req, last, unused;

    wire [s_index-1:0]    idx    = mem_address[s_offset +: s_index];
    wire [s_tag-1:0]      tag_in = mem_address[31 -: s_tag];
    wire [word_sel_w-1:0] off    = mem_address[word_lo +: word_sel_w];
    wire [s_index-1:0]    fset   = cnt[c_bits-1 -: s_index];
    wire [w_bits-1:0]     fway   = cnt[w_bits-1:0];
    wire [s_offset-1:0]   zeros  = '0;

    assign req        = mem_read | mem_write;
    assign last       = &cnt;
    assign victim_sel = any_inv ? inv_way : plru_victim;
    assign hit_line   = data_arr[idx][hit_way];
    assign unused     = ^mem_address[word_lo-1:0];

    plru_tree #(.num_ways(num_ways)) u_plru (
        .bits(plru[idx]),
        .way(hit_way),
        .victim(plru_victim),
        .next_bits(plru_next)
    );

    // tag compare and lowest-index invalid way search on the addressed set
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = num_ways - 1; w >= 0; w--) begin
            if (valid[idx][w] && tag_arr[idx][w] == tag_in) begin
                hit = 1'b1;
                hit_way = w_bits'(w);
            end
            if (!valid[idx][w]) begin
                any_inv = 1'b1;
                inv_way = w_bits'(w);
            end
        end
    end

    // expand byte enables into a line-wide byte mask and merge the write word
    always_comb begin
        merged = hit_line;
        byte_mask = '0;
        for (int b = 0; b < line_bytes; b++) begin
            byte_mask[b] = (b / byte_lanes == int'(off)) && mem_byte_enable[b % byte_lanes];
            merged[8*b +: 8] = byte_mask[b] ? mem_wdata[8*(b % byte_lanes) +: 8] : hit_line[8*b +: 8];
        end
    end

    // next-state and all port outputs
    always_comb begin
        next_state = state;
        mem_resp = 1'b0;
        mem_rdata = '0;
        flush_done = 1'b0;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        pmem_address = '0;
        pmem_wdata = '0;
        case (state)
            LOOKUP: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    mem_rdata = mem_read ? hit_line[word_w*off +: word_w] : '0;
                end else if (req) begin
                    next_state = (valid[idx][victim_sel] && dirty[idx][victim_sel]) ? WRITEBACK : FILL;
                end else if (flush) begin
                    next_state = FLUSH_SCAN;
                end
            end
            WRITEBACK: begin
                pmem_write = 1'b1;
                pmem_address = {tag_arr[idx][victim_q], idx, zeros};
                pmem_wdata = data_arr[idx][victim_q];
                next_state = pmem_resp ? FILL : WRITEBACK;
            end
            FILL: begin
                pmem_read = 1'b1;
                pmem_address = {mem_address[31:s_offset], zeros};
                next_state = pmem_resp ? LOOKUP : FILL;
            end
            FLUSH_SCAN: begin
                if (valid[fset][fway] && dirty[fset][fway]) begin
                    next_state = FLUSH_WB;
                end else if (last) begin
                    flush_done = 1'b1;
                    next_state = LOOKUP;
                end
            end
            FLUSH_WB: begin
                pmem_write = 1'b1;
                pmem_address = {tag_arr[fset][fway], fset, zeros};
                pmem_wdata = data_arr[fset][fway];
                flush_done = pmem_resp && last;
                next_state = pmem_resp ? (last ? LOOKUP : FLUSH_SCAN) : FLUSH_WB;
            end
            default: next_state = LOOKUP;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOOKUP;
        else state <= next_state;
    end

    // valid/dirty/PLRU bookkeeping, latched victim and flush walk counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            victim_q <= '0;
            for (int s = 0; s < num_sets; s++) begin
                plru[s] <= '0;
                for (int w = 0; w < num_ways; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                end
            end
        end else begin
            case (state)
                LOOKUP: begin
                    if (req && hit) begin
                        plru[idx] <= plru_next;
                        if (mem_write) dirty[idx][hit_way] <= 1'b1;
                    end else if (req) begin
                        victim_q <= victim_sel;
                    end
                end
                WRITEBACK: if (pmem_resp) dirty[idx][victim_q] <= 1'b0;
                FILL: begin
                    if (pmem_resp) begin
                        valid[idx][victim_q] <= 1'b1;
                        dirty[idx][victim_q] <= 1'b0;
                    end
                end
                FLUSH_SCAN: if (!(valid[fset][fway] && dirty[fset][fway])) cnt <= cnt + 1'b1;
                FLUSH_WB: begin
                    if (pmem_resp) begin
                        dirty[fset][fway] <= 1'b0;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // tag and line storage; contents are qualified by valid so need no reset
    always_ff @(posedge clk) begin
        if (state == LOOKUP && req && hit && mem_write) data_arr[idx][hit_way] <= merged;
        if (state == FILL && pmem_resp) begin
            data_arr[idx][victim_q] <= pmem_rdata;
            tag_arr[idx][victim_q] <= tag_in;
        end
    end
endmodule

// File: tb/tb_nway_datacache.sv
// tb_nway_datacache: directed vector bench with a small line-memory responder
module tb_nway_datacache;
    logic         clk, rst_n;
    logic [31:0]  mem_address, mem_wdata, mem_rdata, pmem_address;
    logic         mem_read, mem_write, mem_resp, flush, flush_done;
    logic [3:0]   mem_byte_enable;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [255:0] pmem_wdata, pmem_rdata;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] a;
    } tx_t;
    tx_t txq[$];
    logic [255:0] mem [logic [31:0]];

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rd;
        int          cyc;
        int          nrd;
        int          nwr;
        logic [31:0] a0;
    } vec_t;
    vec_t vq[$];

    nway_datacache #(.s_offset(5), .s_index(3), .num_ways(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .flush(flush), .flush_done(flush_done),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [255:0] pat(logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'h1000_0000 + a + 32'(i);
        return l;
    endfunction

    function automatic logic [255:0] line_of(logic [31:0] a);
        return mem.exists(a) ? mem[a] : pat(a);
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // pmem responder: answers each request on its second low phase
    initial begin
        int dly;
        dly = 0;
        pmem_resp = 0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_read && pmem_write) begin
                mismatched++;
                $display("FAIL pmem_both: read and write high together");
            end
            if (!rst_n) begin
                pmem_resp = 0;
                dly = 0;
            end else if (pmem_resp) begin
                pmem_resp = 0;
            end else if (pmem_read || pmem_write) begin
                dly++;
                if (dly == 2) begin
                    dly = 0;
                    pmem_resp = 1;
                    txq.push_back(tx_t'{pmem_write, pmem_address});
                    if (pmem_write) mem[pmem_address] = pmem_wdata;
                    else pmem_rdata = line_of(pmem_address);
                end
            end
        end
    end

    task automatic access(input logic wr, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                          output logic [31:0] rd, output int cyc, output bit to);
        txq.delete();
        @(negedge clk);
        mem_read = !wr;
        mem_write = wr;
        mem_address = a;
        mem_byte_enable = be;
        mem_wdata = wd;
        cyc = 0;
        to = 0;
        forever begin
            #1;
            if (mem_resp) break;
            if (cyc == 200) begin
                to = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        rd = mem_rdata;
        @(negedge clk);
        mem_read = 0;
        mem_write = 0;
    endtask

    task automatic do_flush(input int exp_wr, input logic [31:0] e0, input logic [31:0] e1);
        int scan;
        bit to;
        txq.delete();
        @(negedge clk);
        mem_read = 0;
        mem_write = 0;
        flush = 1;
        scan = 0;
        to = 0;
        @(negedge clk);
        forever begin
            #1;
            if (!pmem_write) scan++;
            if (flush_done) break;
            if (scan > 300) begin
                to = 1;
                break;
            end
            @(negedge clk);
        end
        flush = 0;
        chk("flush_timeout", to, 0);
        chk("flush_scan_cycles", scan, 32);
        chk("flush_nwr", txq.size(), exp_wr);
        for (int i = 0; i < txq.size(); i++) chk($sformatf("flush_tx%0d_is_write", i), txq[i].wr, 1);
        if (txq.size() > 0) chk("flush_addr0", txq[0].a, e0);
        if (txq.size() > 1) chk("flush_addr1", txq[1].a, e1);
        @(negedge clk);
        #1;
        chk("flush_done_one_cycle", flush_done, 0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [255:0] l;
        int cyc, nrd, nwr;
        bit to;
        rst_n = 0;
        mem_read = 0;
        mem_write = 0;
        mem_address = 0;
        mem_byte_enable = 0;
        mem_wdata = 0;
        flush = 0;
        l = pat(32'h40);
        l[95:64] = 32'hDEADBEEF;
        mem[32'h40] = l;

        vq.push_back(vec_t'{0, 32'h040, 4'hF, 0, 32'h1000_0040, 3, 1, 0, 32'h40});
        vq.push_back(vec_t'{0, 32'h048, 4'hF, 0, 32'hDEADBEEF, 0, 0, 0, 0});
        vq.push_back(vec_t'{0, 32'h048, 4'hF, 0, 32'hDEADBEEF, 0, 0, 0, 0});
        vq.push_back(vec_t'{1, 32'h048, 4'b0011, 32'h1122_3344, 0, 0, 0, 0, 0});
        vq.push_back(vec_t'{0, 32'h048, 4'hF, 0, 32'hDEAD3344, 0, 0, 0, 0});
        vq.push_back(vec_t'{0, 32'h140, 4'hF, 0, 32'h1000_0140, 3, 1, 0, 32'h140});
        vq.push_back(vec_t'{0, 32'h244, 4'hF, 0, 32'h1000_0241, 3, 1, 0, 32'h240});
        vq.push_back(vec_t'{0, 32'h34C, 4'hF, 0, 32'h1000_0343, 3, 1, 0, 32'h340});
        vq.push_back(vec_t'{0, 32'h440, 4'hF, 0, 32'h1000_0440, 6, 1, 1, 32'h40});
        vq.push_back(vec_t'{0, 32'h048, 4'hF, 0, 32'hDEAD3344, 3, 1, 0, 32'h40});
        vq.push_back(vec_t'{0, 32'h140, 4'hF, 0, 32'h1000_0140, 0, 0, 0, 0});
        vq.push_back(vec_t'{1, 32'h0E4, 4'hF, 32'hCAFE_F00D, 0, 3, 1, 0, 32'hE0});
        vq.push_back(vec_t'{1, 32'h004, 4'b1100, 32'h1234_5678, 0, 3, 1, 0, 32'h00});
        vq.push_back(vec_t'{0, 32'h004, 4'hF, 0, 32'h1234_0001, 0, 0, 0, 0});

        #2;
        chk("rst_mem_resp", mem_resp, 0);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        foreach (vq[i]) begin
            access(vq[i].wr, vq[i].a, vq[i].be, vq[i].wd, rd, cyc, to);
            nrd = 0;
            nwr = 0;
            foreach (txq[j]) if (txq[j].wr) nwr++; else nrd++;
            chk($sformatf("v%0d_timeout", i), to, 0);
            if (!vq[i].wr) chk($sformatf("v%0d_rdata", i), rd, vq[i].rd);
            chk($sformatf("v%0d_latency", i), cyc, vq[i].cyc);
            chk($sformatf("v%0d_nrd", i), nrd, vq[i].nrd);
            chk($sformatf("v%0d_nwr", i), nwr, vq[i].nwr);
            if (txq.size() > 0) begin
                chk($sformatf("v%0d_addr0", i), txq[0].a, vq[i].a0);
                chk($sformatf("v%0d_first_is_write", i), txq[0].wr, vq[i].nwr > 0);
            end
            if (i == 8) begin
                l = line_of(32'h40);
                chk("evict_wb_word2", l[95:64], 32'hDEAD3344);
                chk("evict_fill_addr", txq[txq.size()-1].a, 32'h440);
            end
        end

        do_flush(2, 32'h00, 32'hE0);
        l = line_of(32'h00);
        chk("flush_line0_word1", l[63:32], 32'h1234_0001);
        l = line_of(32'hE0);
        chk("flush_lineE0_word1", l[63:32], 32'hCAFE_F00D);
        access(0, 32'h004, 4'hF, 0, rd, cyc, to);
        chk("post_flush_hit_rdata", rd, 32'h1234_0001);
        chk("post_flush_hit_latency", cyc, 0);
        chk("post_flush_no_traffic", txq.size(), 0);
        do_flush(0, 0, 0);

        @(negedge clk);
        mem_read = 1;
        mem_address = 32'h0E4;
        mem_byte_enable = 4'hF;
        flush = 1;
        #1;
        chk("simul_read_resp", mem_resp, 1);
        chk("simul_read_rdata", mem_rdata, 32'hCAFE_F00D);
        chk("simul_no_flush_done", flush_done, 0);
        do_flush(0, 0, 0);

        txq.delete();
        @(negedge clk);
        mem_read = 1;
        mem_address = 32'h500;
        to = 1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (pmem_read) begin
                to = 0;
                break;
            end
            @(negedge clk);
        end
        chk("rstfill_saw_pmem_read", to, 0);
        #1;
        rst_n = 0;
        #1;
        chk("rstfill_mem_resp", mem_resp, 0);
        chk("rstfill_pmem_read", pmem_read, 0);
        chk("rstfill_pmem_write", pmem_write, 0);
        chk("rstfill_flush_done", flush_done, 0);
        chk("rstfill_pmem_address", pmem_address, 0);
        chk("rstfill_pmem_wdata", pmem_wdata, 0);
        chk("rstfill_mem_rdata", mem_rdata, 0);
        @(negedge clk);
        mem_read = 0;
        @(negedge clk);
        rst_n = 1;
        access(0, 32'h004, 4'hF, 0, rd, cyc, to);
        chk("after_rst_timeout", to, 0);
        chk("after_rst_miss_latency", cyc, 3);
        chk("after_rst_nreq", txq.size(), 1);
        if (txq.size() > 0) chk("after_rst_fill_addr", txq[0].a, 32'h00);
        chk("after_rst_rdata", rd, 32'h1234_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
